// File: rtl/cache_bus_pkg.sv
// cache_bus_pkg: shared types for the i/d cache bus arbiter.
//   state_e  - arbiter FSM encoding (address phase A_x, data phase W_x)
//   owner_e  - which cache currently owns the bridge port
//   bus_req_t - request payload muxed onto the bridge
package cache_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    A_I  = 3'd1,
    A_D  = 3'd2,
    W_I  = 3'd3,
    W_D  = 3'd4
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // Address-phase state for a given owner.
  function automatic state_e addr_state(input owner_e own);
    return (own == OWN_I) ? A_I : A_D;
  endfunction

  // Data-phase state for a given owner.
  function automatic state_e data_state(input owner_e own);
    return (own == OWN_I) ? W_I : W_D;
  endfunction

endpackage

// File: rtl/cache_bus_arbiter_rr.sv
// rr_arbiter2: two-requester grant (icache / dcache).
//   req_i_i, req_d_i : requests from icache / dcache
//   done_i           : a transaction completed this cycle
//   done_owner_i     : owner of that completed transaction
//   grant_o          : combinational winner (OWN_D when nobody or only D requests)
// Round-robin favours the requester that did not finish last; FIXED_PRIO=1
// makes the dcache win every tie.
module rr_arbiter2
  import cache_bus_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i_i,
  input  logic req_d_i,
  input  logic done_i,
  input  logic done_owner_i,
  output logic grant_o
);

  owner_e last_owner_q;
  owner_e grant;

  // Last completed owner; only completions move the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= OWN_I;
    end else if (done_i) begin
      last_owner_q <= owner_e'(done_owner_i);
    end
  end

  // Tie-break: fixed data-first, or whoever did not complete last.
  always_comb begin
    grant = OWN_D;
    if (req_i_i && req_d_i) begin
      if (FIXED_PRIO) begin
        grant = OWN_D;
      end else begin
        grant = (last_owner_q == OWN_I) ? OWN_D : OWN_I;
      end
    end else if (req_i_i) begin
      grant = OWN_I;
    end
  end

  assign grant_o = grant;

endmodule

// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: shares one sram-like bridge port between icache and dcache.
//   clk, resetn                 : clock, async active-low reset
//   i_* / d_*                   : sram-like slave ports towards icache / dcache
//   m_*                         : sram-like master port towards the AXI bridge
//   i_cnt, d_cnt                : saturating completed-transaction counters
//   proto_err                   : sticky, m_data_ok seen with nothing outstanding
// One transaction in flight; the owner holds the port from grant to data_ok.
// Handshakes are combinational pass-throughs gated by the FSM state so that an
// async reset kills them immediately.
module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_req,
  input  logic                 i_wr,
  input  logic [1:0]           i_size,
  input  logic [31:0]          i_addr,
  input  logic [31:0]          i_wdata,
  output logic [31:0]          i_rdata,
  output logic                 i_addr_ok,
  output logic                 i_data_ok,
  input  logic                 d_req,
  input  logic                 d_wr,
  input  logic [1:0]           d_size,
  input  logic [31:0]          d_addr,
  input  logic [31:0]          d_wdata,
  output logic [31:0]          d_rdata,
  output logic                 d_addr_ok,
  output logic                 d_data_ok,
  output logic                 m_req,
  output logic                 m_wr,
  output logic [1:0]           m_size,
  output logic [31:0]          m_addr,
  output logic [31:0]          m_wdata,
  input  logic [31:0]          m_rdata,
  input  logic                 m_addr_ok,
  input  logic                 m_data_ok,
  output logic [CNT_WIDTH-1:0] i_cnt,
  output logic [CNT_WIDTH-1:0] d_cnt,
  output logic                 proto_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_e                state_q, state_d;
  owner_e                sel;
  logic                  grant;
  logic                  own_req;
  logic                  done;
  logic                  err_set;
  logic [CNT_WIDTH-1:0]  i_cnt_q, d_cnt_q;
  logic                  proto_err_q;
  bus_req_t              i_bus, d_bus, m_bus;

  rr_arbiter2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_rr (
    .clk          (clk),
    .rst_n        (resetn),
    .req_i_i      (i_req),
    .req_d_i      (d_req),
    .done_i       (done),
    .done_owner_i (sel),
    .grant_o      (grant)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, bridge request and completion/error detection.
  always_comb begin
    state_d = state_q;
    sel     = OWN_D;
    own_req = 1'b0;
    m_req   = 1'b0;
    done    = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        err_set = m_data_ok;
        if (i_req || d_req) begin
          state_d = addr_state(owner_e'(grant));
        end
      end
      A_I, A_D: begin
        sel     = (state_q == A_I) ? OWN_I : OWN_D;
        own_req = (sel == OWN_I) ? i_req : d_req;
        // A withdrawn request is never shown to the bridge.
        if (!own_req) begin
          state_d = IDLE;
          err_set = m_data_ok;
        end else begin
          m_req = 1'b1;
          if (m_addr_ok) begin
            if (m_data_ok) begin
              done    = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = data_state(sel);
            end
          end else begin
            err_set = m_data_ok;
          end
        end
      end
      W_I, W_D: begin
        sel = (state_q == W_I) ? OWN_I : OWN_D;
        if (m_data_ok) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshakes reach only the owner.
  assign i_addr_ok = m_req & m_addr_ok & (sel == OWN_I);
  assign d_addr_ok = m_req & m_addr_ok & (sel == OWN_D);
  assign i_data_ok = done & (sel == OWN_I);
  assign d_data_ok = done & (sel == OWN_D);

  // Request payload mux; defaults to the dcache when idle.
  assign i_bus   = '{wr: i_wr, size: i_size, addr: i_addr, wdata: i_wdata};
  assign d_bus   = '{wr: d_wr, size: d_size, addr: d_addr, wdata: d_wdata};
  assign m_bus   = (sel == OWN_I) ? i_bus : d_bus;
  assign m_wr    = m_bus.wr;
  assign m_size  = m_bus.size;
  assign m_addr  = m_bus.addr;
  assign m_wdata = m_bus.wdata;

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  // Saturating completion counters and sticky protocol error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_cnt_q     <= '0;
      d_cnt_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (done && sel == OWN_I && i_cnt_q != CNT_MAX) begin
        i_cnt_q <= i_cnt_q + CNT_WIDTH'(1);
      end
      if (done && sel == OWN_D && d_cnt_q != CNT_MAX) begin
        d_cnt_q <= d_cnt_q + CNT_WIDTH'(1);
      end
      if (err_set) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign i_cnt     = i_cnt_q;
  assign d_cnt     = d_cnt_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb_cache_bus_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model of the arbiter.
module tb_cache_bus_arbiter;

  localparam int unsigned CW      = 4;
  localparam bit          FP      = 1'b0;
  localparam int          CNT_SAT = (1 << CW) - 1;

  logic          clk;
  logic          resetn;
  logic          i_req, i_wr, d_req, d_wr;
  logic [1:0]    i_size, d_size, m_size;
  logic [31:0]   i_addr, i_wdata, d_addr, d_wdata;
  logic [31:0]   i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic          i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic          m_req, m_wr, m_addr_ok, m_data_ok;
  logic [CW-1:0] i_cnt, d_cnt;
  logic          proto_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: is a transaction open, who owns it, was its address taken.
  bit busy, acc, err_m;
  int own, last;
  int cnt_m [2];

  cache_bus_arbiter #(
    .FIXED_PRIO (FP),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .i_req     (i_req),
    .i_wr      (i_wr),
    .i_size    (i_size),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_rdata   (i_rdata),
    .i_addr_ok (i_addr_ok),
    .i_data_ok (i_data_ok),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_size    (d_size),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_addr_ok (d_addr_ok),
    .d_data_ok (d_data_ok),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_size    (m_size),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_addr_ok (m_addr_ok),
    .m_data_ok (m_data_ok),
    .i_cnt     (i_cnt),
    .d_cnt     (d_cnt),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    i_req = 0; i_wr = 0; i_size = 0; i_addr = 0; i_wdata = 0;
    d_req = 0; d_wr = 0; d_size = 0; d_addr = 0; d_wdata = 0;
    m_rdata = 0; m_addr_ok = 0; m_data_ok = 0;
  endtask

  task automatic model_reset();
    busy = 0; acc = 0; err_m = 0; own = 0; last = 0;
    cnt_m[0] = 0; cnt_m[1] = 0;
  endtask

  // Called just after a falling edge with inputs already driven; compares,
  // advances the model over the rising edge, returns at the next falling edge.
  task automatic cycle();
    bit own_req, addr_live, done;
    int sel;
    #1;
    check("i_cnt", 32'(i_cnt), 32'(cnt_m[0]));
    check("d_cnt", 32'(d_cnt), 32'(cnt_m[1]));
    check("proto_err", 32'(proto_err), 32'(err_m));
    own_req   = busy && ((own == 1) ? d_req : i_req);
    addr_live = busy && !acc && own_req;
    done      = busy && m_data_ok && (acc || (addr_live && m_addr_ok));
    sel       = busy ? own : 1;
    check("m_req", 32'(m_req), 32'(addr_live));
    check("i_addr_ok", 32'(i_addr_ok), 32'(addr_live && m_addr_ok && own == 0));
    check("d_addr_ok", 32'(d_addr_ok), 32'(addr_live && m_addr_ok && own == 1));
    check("i_data_ok", 32'(i_data_ok), 32'(done && own == 0));
    check("d_data_ok", 32'(d_data_ok), 32'(done && own == 1));
    check("m_wr", 32'(m_wr), 32'((sel == 1) ? d_wr : i_wr));
    check("m_size", 32'(m_size), 32'((sel == 1) ? d_size : i_size));
    check("m_addr", m_addr, (sel == 1) ? d_addr : i_addr);
    check("m_wdata", m_wdata, (sel == 1) ? d_wdata : i_wdata);
    check("i_rdata", i_rdata, m_rdata);
    check("d_rdata", d_rdata, m_rdata);
    if (m_data_ok && !done) err_m = 1;
    if (!busy) begin
      if (i_req || d_req) begin
        busy = 1; acc = 0;
        if (i_req && d_req) own = FP ? 1 : 1 - last;
        else                own = d_req ? 1 : 0;
      end
    end else if (done) begin
      if (cnt_m[own] < CNT_SAT) cnt_m[own]++;
      last = own; busy = 0;
    end else if (!acc && !own_req) begin
      busy = 0;
    end else if (!acc && m_addr_ok) begin
      acc = 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1;
    model_reset();
  endtask

  initial begin
    resetn = 1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset state.
    cycle();
    check("rst_m_req", 32'(m_req), 32'd0);

    // Single icache read.
    i_req = 1; i_addr = 32'h1FC0_0000;
    cycle();                              // IDLE -> A_I
    m_addr_ok = 1;
    cycle();                              // A_I accepted
    i_req = 0; m_addr_ok = 0;
    cycle();                              // W_I waiting
    m_data_ok = 1; m_rdata = 32'hDEAD_BEEF;
    #1 check("ird_data_ok", 32'(i_data_ok), 32'd1);
    check("ird_rdata", i_rdata, 32'hDEAD_BEEF);
    cycle();
    idle_inputs();
    cycle();
    check("ird_icnt", 32'(i_cnt), 32'd1);
    check("ird_dcnt", 32'(d_cnt), 32'd0);

    // Both request continuously; bridge answers in the address cycle.
    do_reset();
    i_req = 1; d_req = 1; m_addr_ok = 1;
    for (int k = 0; k < 8; k++) begin
      m_data_ok = (k % 2 == 1);           // only during A_x, so no spurious data_ok
      cycle();
    end
    idle_inputs();
    cycle();
    check("alt_icnt", 32'(i_cnt), 32'd2);
    check("alt_dcnt", 32'(d_cnt), 32'd2);
    check("alt_err", 32'(proto_err), 32'd0);

    // Dcache write-back then refill.
    do_reset();
    d_req = 1; d_wr = 1; d_addr = 32'h0040_0010; d_wdata = 32'h1234_5678;
    cycle();
    m_addr_ok = 1;
    #1 check("wb_m_wr", 32'(m_wr), 32'd1);
    check("wb_m_wdata", m_wdata, 32'h1234_5678);
    cycle();
    d_req = 0; m_addr_ok = 0; m_data_ok = 1;
    cycle();
    m_data_ok = 0; d_req = 1; d_wr = 0; d_addr = 32'h8000_0010;
    cycle();
    m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h0BAD_F00D;
    #1 check("rf_m_wr", 32'(m_wr), 32'd0);
    check("rf_d_both_ok", 32'({d_addr_ok, d_data_ok}), 32'd3);
    cycle();
    idle_inputs();
    cycle();
    check("rf_dcnt", 32'(d_cnt), 32'd2);

    // Spurious m_data_ok while idle.
    do_reset();
    m_data_ok = 1;
    cycle();
    m_data_ok = 0;
    cycle();
    check("spur_err", 32'(proto_err), 32'd1);
    cycle();

    // Random traffic; counters are narrow so they reach saturation.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      i_req     = ($urandom_range(0, 9) < 7);
      d_req     = ($urandom_range(0, 9) < 6);
      i_wr      = 1'($urandom);
      d_wr      = 1'($urandom);
      i_size    = 2'($urandom);
      d_size    = 2'($urandom);
      i_addr    = $urandom;
      d_addr    = $urandom;
      i_wdata   = $urandom;
      d_wdata   = $urandom;
      m_rdata   = $urandom;
      m_addr_ok = ($urandom_range(0, 9) < 5);
      m_data_ok = ($urandom_range(0, 9) < 4);
      cycle();
    end
    check("sat_icnt", 32'(i_cnt), 32'(CNT_SAT));
    check("sat_dcnt", 32'(d_cnt), 32'(CNT_SAT));

    // Reset during the data phase of an icache read.
    do_reset();
    i_req = 1;
    cycle();
    m_addr_ok = 1;
    cycle();
    m_addr_ok = 1; m_data_ok = 1;
    #1 check("mid_pre_dok", 32'(i_data_ok), 32'd1);
    resetn = 0;
    #1;
    check("mid_m_req", 32'(m_req), 32'd0);
    check("mid_oks", 32'({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}), 32'd0);
    @(negedge clk);
    idle_inputs();
    resetn = 1;
    model_reset();
    cycle();
    check("mid_icnt", 32'(i_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
